// File: rtl/clpoly_div64.sv
// Iterative GF(2) polynomial divider: 64-bit dividend by 32-bit divisor.
// The divisor is left-aligned once so each retired bit needs only a fixed-position XOR.
module clpoly_div64 #(
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst_l,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] dividend,
  input  logic [31:0] divisor,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] quotient,
  output logic [31:0] remainder,
  output logic        div_zero,
  output logic        busy
);

  localparam int unsigned N = 64 / BITS_PER_CYCLE;

  typedef enum logic [1:0] {StIdle, StNorm, StDiv, StDone} state_e;

  state_e      state_q, state_d;
  logic [63:0] dvd_q, dvd_d;
  logic [31:0] dsr_q, dsr_d;
  logic [31:0] rem_q, rem_d;
  logic [63:0] quo_q, quo_d;
  logic [4:0]  shift_q, shift_d;
  logic [6:0]  cnt_q, cnt_d;
  logic        dz_q, dz_d;

  logic [4:0]  deg;
  logic [4:0]  norm_shift;
  logic [95:0] norm_wide;
  logic [31:0] step_r, step_t;
  logic [63:0] step_q, step_a;

  always_comb begin
    deg = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (dsr_q[i]) deg = 5'(i);
    end
  end

  // Scaling dividend and divisor by the same x^s leaves the quotient unchanged;
  // the top s dividend bits seed the partial remainder.
  assign norm_shift = 5'd31 - deg;
  assign norm_wide  = {32'b0, dvd_q} << norm_shift;

  always_comb begin
    step_r = rem_q;
    step_q = quo_q;
    step_a = dvd_q;
    step_t = '0;
    for (int unsigned k = 0; k < BITS_PER_CYCLE; k++) begin
      step_t = {step_r[30:0], step_a[63]};
      step_q = {step_q[62:0], step_t[31]};
      if (step_t[31]) step_t = step_t ^ dsr_q;
      step_r = step_t;
      step_a = {step_a[62:0], 1'b0};
    end
  end

  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dsr_d   = dsr_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    dz_d    = dz_q;
    if (flush) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            dvd_d   = dividend;
            dsr_d   = divisor;
            state_d = StNorm;
          end
        end
        StNorm: begin
          quo_d = '0;
          if (dsr_q == '0) begin
            dz_d    = 1'b1;
            rem_d   = dvd_q[31:0];
            shift_d = '0;
            state_d = StDone;
          end else begin
            dz_d    = 1'b0;
            shift_d = norm_shift;
            dsr_d   = dsr_q << norm_shift;
            rem_d   = norm_wide[95:64];
            dvd_d   = norm_wide[63:0];
            cnt_d   = 7'(N);
            state_d = StDiv;
          end
        end
        StDiv: begin
          rem_d = step_r;
          quo_d = step_q;
          dvd_d = step_a;
          cnt_d = cnt_q - 7'd1;
          if (cnt_q == 7'd1) state_d = StDone;
        end
        StDone: begin
          if (out_ready) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q <= StIdle;
      dvd_q   <= '0;
      dsr_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      shift_q <= '0;
      cnt_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dsr_q   <= dsr_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      dz_q    <= dz_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign quotient  = quo_q;
  assign remainder = rem_q >> shift_q;
  assign div_zero  = dz_q;

endmodule
